// File: rtl/synch_bin_count_monitor_if.sv
// synch_bin_count_monitor_if: observed counter bus and monitor results.
interface synch_bin_count_monitor_if #(
    parameter int Nbits = 4,
    parameter int Cbits = 8
);
    logic             ena;
    logic             clr;
    logic [Nbits-1:0] counter;
    logic             step_up;
    logic             step_dn;
    logic             hold;
    logic             jump;
    logic [Nbits-1:0] jump_value;
    logic             wrap_up;
    logic             wrap_dn;
    logic             dir;
    logic             tracking;
    logic [Cbits-1:0] up_cnt;
    logic [Cbits-1:0] dn_cnt;
    logic [Cbits-1:0] jump_cnt;
    modport master (
        output ena, clr, counter,
        input  step_up, step_dn, hold, jump, jump_value, wrap_up, wrap_dn,
               dir, tracking, up_cnt, dn_cnt, jump_cnt
    );
    modport slave (
        input  ena, clr, counter,
        output step_up, step_dn, hold, jump, jump_value, wrap_up, wrap_dn,
               dir, tracking, up_cnt, dn_cnt, jump_cnt
    );
endinterface

// File: rtl/synch_bin_count_monitor.sv
// synch_bin_count_monitor: classifies each sampled counter value as hold/up/down/jump with saturating stats.
module synch_bin_count_monitor #(
    parameter int Nbits = 4,
    parameter int Cbits = 8
) (
    input logic                      clk,
    input logic                      rst,
    synch_bin_count_monitor_if.slave bus
);
    typedef enum logic {IDLE, TRACK} state_t;
    localparam logic [Nbits-1:0] ONES = '1;
    localparam logic [Cbits-1:0] CMAX = '1;
    if (Nbits < 2) begin : g_chk
        $error("Nbits must be >= 2");
    end
    state_t           state_q, state_d;
    logic [Nbits-1:0] prev_q, prev_d, jv_q, jv_d, diff;
    logic             up_q, up_d, dn_q, dn_d, hold_q, hold_d, jump_q, jump_d;
    logic             wup_q, wup_d, wdn_q, wdn_d, dir_q, dir_d;
    logic             is_up, is_dn, is_hold;
    logic [Cbits-1:0] uc_q, uc_d, dc_q, dc_d, jc_q, jc_d;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            prev_q  <= '0;
            jv_q    <= '0;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
            hold_q  <= 1'b0;
            jump_q  <= 1'b0;
            wup_q   <= 1'b0;
            wdn_q   <= 1'b0;
            dir_q   <= 1'b0;
            uc_q    <= '0;
            dc_q    <= '0;
            jc_q    <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            jv_q    <= jv_d;
            up_q    <= up_d;
            dn_q    <= dn_d;
            hold_q  <= hold_d;
            jump_q  <= jump_d;
            wup_q   <= wup_d;
            wdn_q   <= wdn_d;
            dir_q   <= dir_d;
            uc_q    <= uc_d;
            dc_q    <= dc_d;
            jc_q    <= jc_d;
        end
    end
    // A load landing on prev+-1 is indistinguishable from a step and is reported as one.
    assign diff    = bus.counter - prev_q;
    assign is_hold = diff == '0;
    assign is_up   = diff == Nbits'(1);
    assign is_dn   = diff == ONES;
    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        jv_d    = jv_q;
        dir_d   = dir_q;
        up_d    = 1'b0;
        dn_d    = 1'b0;
        hold_d  = 1'b0;
        jump_d  = 1'b0;
        wup_d   = 1'b0;
        wdn_d   = 1'b0;
        if (bus.ena) begin
            state_d = TRACK;
            prev_d  = bus.counter;
            if (state_q == TRACK) begin
                hold_d = is_hold;
                up_d   = is_up;
                dn_d   = is_dn;
                jump_d = !(is_hold || is_up || is_dn);
                wup_d  = is_up && prev_q == ONES;
                wdn_d  = is_dn && prev_q == '0;
                dir_d  = is_up ? 1'b1 : is_dn ? 1'b0 : dir_q;
                jv_d   = jump_d ? bus.counter : jv_q;
            end
        end
    end
    // Clear wins over a same-edge increment; counters stick at all-ones.
    always_comb begin
        uc_d = bus.clr ? '0 : (up_d && uc_q != CMAX) ? uc_q + 1'b1 : uc_q;
        dc_d = bus.clr ? '0 : (dn_d && dc_q != CMAX) ? dc_q + 1'b1 : dc_q;
        jc_d = bus.clr ? '0 : (jump_d && jc_q != CMAX) ? jc_q + 1'b1 : jc_q;
    end
    assign bus.step_up    = up_q;
    assign bus.step_dn    = dn_q;
    assign bus.hold       = hold_q;
    assign bus.jump       = jump_q;
    assign bus.jump_value = jv_q;
    assign bus.wrap_up    = wup_q;
    assign bus.wrap_dn    = wdn_q;
    assign bus.dir        = dir_q;
    assign bus.tracking   = state_q == TRACK;
    assign bus.up_cnt     = uc_q;
    assign bus.dn_cnt     = dc_q;
    assign bus.jump_cnt   = jc_q;
endmodule

// File: tb/tb_synch_bin_count_monitor.sv
// tb_synch_bin_count_monitor: vector table with expected-result queue plus corner-case sequences.
module tb_synch_bin_count_monitor;
    typedef struct {
        logic       ena;
        logic       clr;
        logic [3:0] ctr;
        logic [3:0] ev;
        logic [1:0] wr;
        logic       dir;
        logic       trk;
        logic [3:0] jv;
        logic [7:0] uc;
        logic [7:0] dc;
        logic [7:0] jc;
    } vec_t;
    logic clk, rst;
    int   n_run, n_fail;
    vec_t tbl[20];
    logic [35:0] q[$];
    synch_bin_count_monitor_if #(.Nbits(4), .Cbits(8)) ba ();
    synch_bin_count_monitor_if #(.Nbits(4), .Cbits(2)) bb ();
    synch_bin_count_monitor #(.Nbits(4), .Cbits(8)) dut_a (.clk(clk), .rst(rst), .bus(ba));
    synch_bin_count_monitor #(.Nbits(4), .Cbits(2)) dut_b (.clk(clk), .rst(rst), .bus(bb));
    assign bb.ena     = ba.ena;
    assign bb.clr     = ba.clr;
    assign bb.counter = ba.counter;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    function automatic vec_t v(input logic e, c, input logic [3:0] ct, ev, input logic [1:0] wr,
                               input logic d, t, input logic [3:0] jv, input logic [7:0] uc, dc, jc);
        vec_t r;
        r.ena = e; r.clr = c; r.ctr = ct; r.ev = ev; r.wr = wr; r.dir = d; r.trk = t;
        r.jv = jv; r.uc = uc; r.dc = dc; r.jc = jc;
        return r;
    endfunction
    function automatic logic [35:0] pack_a();
        return {ba.step_up, ba.step_dn, ba.hold, ba.jump, ba.wrap_up, ba.wrap_dn, ba.dir,
                ba.tracking, ba.jump_value, ba.up_cnt, ba.dn_cnt, ba.jump_cnt};
    endfunction
    function automatic logic [35:0] pack_b();
        return {18'd0, bb.step_up, bb.step_dn, bb.hold, bb.jump, bb.wrap_up, bb.wrap_dn, bb.dir,
                bb.tracking, bb.jump_value, bb.up_cnt, bb.dn_cnt, bb.jump_cnt};
    endfunction
    task automatic check(input string name, input logic [35:0] act, exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic drive(input logic e, c, input logic [3:0] ct);
        @(negedge clk);
        ba.ena = e;
        ba.clr = c;
        ba.counter = ct;
        @(posedge clk);
        #1;
    endtask
    initial begin
        n_run = 0;
        n_fail = 0;
        //            ena clr ctr  ev(u,d,h,j) wr   dir trk jv  up dn jmp
        tbl[0]  = v(1, 0, 0,  4'b0000, 2'b00, 0, 1, 0,  0, 0, 0);
        tbl[1]  = v(1, 0, 13, 4'b0001, 2'b00, 0, 1, 13, 0, 0, 1);
        tbl[2]  = v(1, 0, 14, 4'b1000, 2'b00, 1, 1, 13, 1, 0, 1);
        tbl[3]  = v(1, 0, 15, 4'b1000, 2'b00, 1, 1, 13, 2, 0, 1);
        tbl[4]  = v(1, 0, 0,  4'b1000, 2'b10, 1, 1, 13, 3, 0, 1);
        tbl[5]  = v(1, 0, 1,  4'b1000, 2'b00, 1, 1, 13, 4, 0, 1);
        tbl[6]  = v(1, 0, 2,  4'b1000, 2'b00, 1, 1, 13, 5, 0, 1);
        tbl[7]  = v(1, 0, 1,  4'b0100, 2'b00, 0, 1, 13, 5, 1, 1);
        tbl[8]  = v(1, 0, 0,  4'b0100, 2'b00, 0, 1, 13, 5, 2, 1);
        tbl[9]  = v(1, 0, 15, 4'b0100, 2'b01, 0, 1, 13, 5, 3, 1);
        tbl[10] = v(1, 0, 3,  4'b0001, 2'b00, 0, 1, 3,  5, 3, 2);
        tbl[11] = v(1, 0, 7,  4'b0001, 2'b00, 0, 1, 7,  5, 3, 3);
        tbl[12] = v(0, 0, 12, 4'b0000, 2'b00, 0, 1, 7,  5, 3, 3);
        tbl[13] = v(1, 0, 12, 4'b0001, 2'b00, 0, 1, 12, 5, 3, 4);
        tbl[14] = v(1, 0, 12, 4'b0010, 2'b00, 0, 1, 12, 5, 3, 4);
        tbl[15] = v(1, 0, 12, 4'b0010, 2'b00, 0, 1, 12, 5, 3, 4);
        tbl[16] = v(1, 1, 13, 4'b1000, 2'b00, 1, 1, 12, 0, 0, 0);
        tbl[17] = v(0, 0, 13, 4'b0000, 2'b00, 1, 1, 12, 0, 0, 0);
        tbl[18] = v(1, 0, 15, 4'b0001, 2'b00, 1, 1, 15, 0, 0, 1);
        tbl[19] = v(1, 1, 14, 4'b0100, 2'b00, 0, 1, 15, 0, 0, 0);
        rst = 1'b1;
        ba.ena = 1'b0;
        ba.clr = 1'b0;
        ba.counter = 4'd0;
        #50 rst = 1'b0;
        #1 check("reset_state", pack_a(), 36'd0);
        for (int i = 0; i < 20; i++) begin
            q.push_back({tbl[i].ev, tbl[i].wr, tbl[i].dir, tbl[i].trk, tbl[i].jv,
                         tbl[i].uc, tbl[i].dc, tbl[i].jc});
            drive(tbl[i].ena, tbl[i].clr, tbl[i].ctr);
            check($sformatf("vec%0d", i), pack_a(), q.pop_front());
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(1, 0, 0);
        for (int i = 1; i <= 5; i++) drive(1, 0, 4'(i));
        check("sat_up_cnt", {34'd0, bb.up_cnt}, 36'd3);
        check("sat_a_up_cnt", {28'd0, ba.up_cnt}, 36'd5);
        drive(1, 1, 6);
        check("clr_step_up", {33'd0, bb.step_up, bb.up_cnt}, {33'd0, 1'b1, 2'd0});
        drive(1, 0, 7);
        check("after_clr_cnt", {34'd0, bb.up_cnt}, 36'd1);
        drive(1, 0, 8);
        #2 rst = 1'b1;
        #1 check("midrst_a", pack_a(), 36'd0);
        check("midrst_b", pack_b(), 36'd0);
        @(negedge clk);
        rst = 1'b0;
        ba.ena = 1'b1;
        ba.clr = 1'b0;
        ba.counter = 4'd9;
        @(posedge clk);
        #1 check("ref_after_rst", pack_a(), {4'b0000, 2'b00, 1'b0, 1'b1, 4'd0, 8'd0, 8'd0, 8'd0});
        drive(1, 0, 10);
        check("step_after_ref", pack_a(), {4'b1000, 2'b00, 1'b1, 1'b1, 4'd0, 8'd1, 8'd0, 8'd0});
        @(negedge clk);
        ba.clr = 1'b1;
        rst = 1'b1;
        #1 check("rst_over_clr", pack_a(), 36'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
